// File: rtl/ajc_instr_fetch.sv
// Instruction fetch stage: reads one- or two-byte instructions from program memory,
// presents IW/MA over a valid/ready handshake and owns the program counter.
module ajc_instr_fetch #(
    parameter int unsigned AW = 8,
    parameter int unsigned CW = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    output logic [AW-1:0] o_PM_Addr,
    output logic          o_PM_Rd,
    input  logic [7:0]    i_PM_Data,
    output logic [7:0]    o_IW,
    output logic [7:0]    o_MA,
    output logic          o_IW_Valid,
    input  logic          i_CU_Ready,
    input  logic          i_Redirect,
    input  logic [AW-1:0] i_Redirect_Addr,
    output logic [AW-1:0] o_PC,
    output logic [CW-1:0] o_InstrCount
);

    typedef enum logic [2:0] {
        StFetch,
        StWaitIw,
        StFetchMa,
        StWaitMa,
        StIssue
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_pc;
    logic [7:0]      r_iw;
    logic [7:0]      r_ma;
    logic [CW-1:0]   r_instr_count;
    logic            w_pm_rd;
    logic            w_iw_valid;
    logic            w_two_byte;
    logic            w_handshake;

    // LD, ST and JUMP carry an address operand in the following byte.
    assign w_two_byte  = (i_PM_Data[7:4] == 4'b1011) || (i_PM_Data[7:4] == 4'b1100) ||
                         (i_PM_Data[7:4] == 4'b1101);
    assign w_handshake = (r_state == StIssue) && i_CU_Ready;

    always_comb begin
        w_state_next = r_state;
        w_pm_rd      = 1'b0;
        w_iw_valid   = 1'b0;
        unique case (r_state)
            StFetch: begin
                w_pm_rd      = 1'b1;
                w_state_next = StWaitIw;
            end
            StWaitIw: begin
                w_state_next = w_two_byte ? StFetchMa : StIssue;
            end
            StFetchMa: begin
                w_pm_rd      = 1'b1;
                w_state_next = StWaitMa;
            end
            StWaitMa: begin
                w_state_next = StIssue;
            end
            StIssue: begin
                w_iw_valid = 1'b1;
                if (i_CU_Ready) begin
                    w_state_next = StFetch;
                end
            end
            default: begin
                w_state_next = StFetch;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= StFetch;
            r_pc          <= '0;
            r_iw          <= '0;
            r_ma          <= '0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StWaitIw) begin
                r_iw <= i_PM_Data;
                r_ma <= '0;
                r_pc <= r_pc + 1'b1;
            end
            if (r_state == StWaitMa) begin
                r_ma <= i_PM_Data;
                r_pc <= r_pc + 1'b1;
            end
            // Redirect only counts when the jump instruction is actually consumed.
            if (w_handshake) begin
                r_instr_count <= r_instr_count + 1'b1;
                if (i_Redirect) begin
                    r_pc <= i_Redirect_Addr;
                end
            end
        end
    end

    assign o_PM_Addr    = r_pc;
    assign o_PM_Rd      = w_pm_rd & ~Reset;
    assign o_IW_Valid   = w_iw_valid & ~Reset;
    assign o_IW         = r_iw;
    assign o_MA         = r_ma;
    assign o_PC         = r_pc;
    assign o_InstrCount = r_instr_count;

endmodule

// File: tb/tb_ajc_instr_fetch.sv
// Self-checking bench for ajc_instr_fetch: program memory model plus a scoreboard of
// expected {IW, MA, PC} entries popped at each handshake.
module tb_ajc_instr_fetch;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] pm_addr;
    logic       pm_rd;
    logic [7:0] pm_data;
    logic [7:0] iw;
    logic [7:0] ma;
    logic       iw_valid;
    logic       cu_ready = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_addr = 8'h00;
    logic [7:0] pc;
    logic [3:0] instr_count;

    logic [7:0] mem [0:255];

    typedef struct packed {
        logic [7:0] iw;
        logic [7:0] ma;
        logic [7:0] pc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rd_log[$];
    int         total  = 0;
    int         passed = 0;

    always #5 Clock = ~Clock;

    ajc_instr_fetch #(
        .AW(8),
        .CW(4)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .o_PM_Addr      (pm_addr),
        .o_PM_Rd        (pm_rd),
        .i_PM_Data      (pm_data),
        .o_IW           (iw),
        .o_MA           (ma),
        .o_IW_Valid     (iw_valid),
        .i_CU_Ready     (cu_ready),
        .i_Redirect     (redirect),
        .i_Redirect_Addr(redirect_addr),
        .o_PC           (pc),
        .o_InstrCount   (instr_count)
    );

    // Registered read: data appears the cycle after the strobe.
    always @(posedge Clock) if (pm_rd) pm_data <= mem[pm_addr];

    always @(negedge Clock) if (pm_rd) rd_log.push_back(pm_addr);

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1);
    end

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // Leaves the bench at the sample point of cycle 0.
    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        exp_t e;
        cu_ready = 1'b1;
        Reset    = 1'b1;
        repeat (3) @(negedge Clock);
        total++;
        if ({pm_rd, iw_valid} !== 2'b00)
            $display("FAIL reset_strobes: got rd=%b valid=%b want 0 0", pm_rd, iw_valid);
        else passed++;
        e = '{8'h00, 8'h00, 8'h00};
        total++;
        if ({iw, ma, pc, instr_count} !== {e, 4'h0})
            $display("FAIL reset_regs: got iw=%h ma=%h pc=%h cnt=%h want 0", iw, ma, pc,
                     instr_count);
        else passed++;
    endtask

    task automatic test_one_byte();
        exp_t e;
        fill_mem(8'h06);
        sb.push_back('{8'h06, 8'h00, 8'h01});
        cu_ready = 1'b1;
        redirect = 1'b0;
        do_reset();
        total++;
        if ({pm_rd, pm_addr} !== {1'b1, 8'h00})
            $display("FAIL one_byte_c0: got rd=%b addr=%h want 1 00", pm_rd, pm_addr);
        else passed++;
        repeat (2) @(negedge Clock);
        e = sb.pop_front();
        total++;
        if ({iw_valid, iw, ma, pc} !== {1'b1, e})
            $display("FAIL one_byte_issue: got v=%b %h %h %h want 1 %h", iw_valid, iw, ma, pc, e);
        else passed++;
        @(negedge Clock);
        total++;
        if ({instr_count, pm_addr} !== {4'h1, 8'h01})
            $display("FAIL one_byte_c3: got cnt=%h addr=%h want 1 01", instr_count, pm_addr);
        else passed++;
    endtask

    task automatic test_two_byte();
        exp_t e;
        fill_mem(8'h06);
        mem[0] = 8'hB4;
        mem[1] = 8'h20;
        sb.push_back('{8'hB4, 8'h20, 8'h02});
        cu_ready = 1'b1;
        rd_log.delete();
        do_reset();
        repeat (2) @(negedge Clock);
        total++;
        if ({iw_valid, pm_rd, pm_addr} !== {1'b0, 1'b1, 8'h01})
            $display("FAIL two_byte_c2: got v=%b rd=%b addr=%h want 0 1 01", iw_valid, pm_rd,
                     pm_addr);
        else passed++;
        repeat (2) @(negedge Clock);
        e = sb.pop_front();
        total++;
        if ({iw_valid, iw, ma, pc} !== {1'b1, e})
            $display("FAIL two_byte_issue: got v=%b %h %h %h want 1 %h", iw_valid, iw, ma, pc, e);
        else passed++;
        total++;
        if (rd_log.size() != 2 || rd_log[0] !== 8'h00 || rd_log[1] !== 8'h01)
            $display("FAIL two_byte_reads: got %0d reads want 2 (00,01)", rd_log.size());
        else passed++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        fill_mem(8'h06);
        mem[0] = 8'hB4;
        mem[1] = 8'h55;
        sb.push_back('{8'hB4, 8'h55, 8'h02});
        cu_ready      = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 8'h80;
        do_reset();
        repeat (4) @(negedge Clock);
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({iw_valid, pm_rd, iw, ma, pc} !== {2'b10, 8'hB4, 8'h55, 8'h02})
                $display("FAIL stall_%0d: got v=%b rd=%b %h %h %h want 1 0 b4 55 02", i,
                         iw_valid, pm_rd, iw, ma, pc);
            else passed++;
            redirect = (i % 2 == 0);
            @(negedge Clock);
        end
        redirect = 1'b0;
        cu_ready = 1'b1;
        e = sb.pop_front();
        total++;
        if ({iw_valid, iw, ma, pc} !== {1'b1, e})
            $display("FAIL stall_release: got v=%b %h %h %h want 1 %h", iw_valid, iw, ma, pc, e);
        else passed++;
        @(negedge Clock);
        total++;
        if ({iw_valid, pm_rd, pm_addr, instr_count} !== {2'b01, 8'h02, 4'h1})
            $display("FAIL stall_after: got v=%b rd=%b addr=%h cnt=%h want 0 1 02 1", iw_valid,
                     pm_rd, pm_addr, instr_count);
        else passed++;
        cu_ready = 1'b0;
        repeat (6) @(negedge Clock);
        total++;
        if ({iw_valid, iw, instr_count} !== {1'b1, 8'h06, 4'h1})
            $display("FAIL stall_once: got v=%b iw=%h cnt=%h want 1 06 1", iw_valid, iw,
                     instr_count);
        else passed++;
    endtask

    task automatic test_jump();
        exp_t e;
        bit   seen12;
        fill_mem(8'h06);
        mem[8'h10] = 8'hD1;
        mem[8'h11] = 8'h40;
        sb.push_back('{8'h06, 8'h00, 8'h01});
        sb.push_back('{8'hD1, 8'h40, 8'h12});
        cu_ready      = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 8'h10;
        rd_log.delete();
        do_reset();
        repeat (2) @(negedge Clock);
        e = sb.pop_front();
        total++;
        if ({iw_valid, iw, ma, pc} !== {1'b1, e})
            $display("FAIL jump_first: got v=%b %h %h %h want 1 %h", iw_valid, iw, ma, pc, e);
        else passed++;
        @(negedge Clock);
        total++;
        if ({pm_rd, pm_addr} !== {1'b1, 8'h10})
            $display("FAIL jump_to10: got rd=%b addr=%h want 1 10", pm_rd, pm_addr);
        else passed++;
        redirect_addr = 8'h40;
        repeat (4) @(negedge Clock);
        e = sb.pop_front();
        total++;
        if ({iw_valid, iw, ma, pc} !== {1'b1, e})
            $display("FAIL jump_issue: got v=%b %h %h %h want 1 %h", iw_valid, iw, ma, pc, e);
        else passed++;
        @(negedge Clock);
        total++;
        if ({pm_rd, pm_addr} !== {1'b1, 8'h40})
            $display("FAIL jump_to40: got rd=%b addr=%h want 1 40", pm_rd, pm_addr);
        else passed++;
        redirect = 1'b0;
        repeat (6) @(negedge Clock);
        seen12 = 1'b0;
        foreach (rd_log[i]) if (rd_log[i] === 8'h12) seen12 = 1'b1;
        total++;
        if (seen12 !== 1'b0) $display("FAIL jump_no_12: got read of 12 want none");
        else passed++;
    endtask

    task automatic test_wrap();
        exp_t e;
        fill_mem(8'h06);
        mem[8'hFF] = 8'hC8;
        mem[8'h00] = 8'h33;
        sb.push_back('{8'h33, 8'h00, 8'h01});
        sb.push_back('{8'hC8, 8'h33, 8'h01});
        cu_ready      = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 8'hFF;
        do_reset();
        repeat (2) @(negedge Clock);
        e = sb.pop_front();
        total++;
        if ({iw_valid, iw, ma, pc} !== {1'b1, e})
            $display("FAIL wrap_first: got v=%b %h %h %h want 1 %h", iw_valid, iw, ma, pc, e);
        else passed++;
        @(negedge Clock);
        redirect = 1'b0;
        total++;
        if ({pm_rd, pm_addr} !== {1'b1, 8'hFF})
            $display("FAIL wrap_ff: got rd=%b addr=%h want 1 ff", pm_rd, pm_addr);
        else passed++;
        repeat (4) @(negedge Clock);
        e = sb.pop_front();
        total++;
        if ({iw_valid, iw, ma, pc} !== {1'b1, e})
            $display("FAIL wrap_issue: got v=%b %h %h %h want 1 %h", iw_valid, iw, ma, pc, e);
        else passed++;
    endtask

    task automatic test_count_wrap();
        int hs  = 0;
        int cyc = 0;
        fill_mem(8'h06);
        cu_ready = 1'b1;
        redirect = 1'b0;
        do_reset();
        while (hs < 17 && cyc < 200) begin
            if (iw_valid && cu_ready) hs++;
            @(negedge Clock);
            cyc++;
        end
        total++;
        if (hs != 17 || cyc != 51)
            $display("FAIL count_rate: got %0d handshakes in %0d cycles want 17 in 51", hs, cyc);
        else passed++;
        total++;
        if (instr_count !== 4'h1)
            $display("FAIL count_wrap: got cnt=%h want 1", instr_count);
        else passed++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        fill_mem(8'h06);
        mem[1] = 8'hB4;
        mem[2] = 8'h20;
        sb.push_back('{8'h06, 8'h00, 8'h01});
        sb.push_back('{8'h06, 8'h00, 8'h01});
        cu_ready = 1'b1;
        do_reset();
        repeat (2) @(negedge Clock);
        e = sb.pop_front();
        total++;
        if ({iw_valid, iw, ma, pc} !== {1'b1, e})
            $display("FAIL rmid_first: got v=%b %h %h %h want 1 %h", iw_valid, iw, ma, pc, e);
        else passed++;
        repeat (3) @(negedge Clock);
        @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        total++;
        if ({iw_valid, pm_rd, iw} !== {2'b00, 8'hB4})
            $display("FAIL rmid_strobes: got v=%b rd=%b iw=%h want 0 0 b4", iw_valid, pm_rd, iw);
        else passed++;
        @(negedge Clock);
        total++;
        if ({pc, iw, ma, instr_count} !== {24'h0, 4'h0})
            $display("FAIL rmid_regs: got pc=%h iw=%h ma=%h cnt=%h want 0", pc, iw, ma,
                     instr_count);
        else passed++;
        @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        total++;
        if ({pm_rd, pm_addr} !== {1'b1, 8'h00})
            $display("FAIL rmid_restart: got rd=%b addr=%h want 1 00", pm_rd, pm_addr);
        else passed++;
        repeat (2) @(negedge Clock);
        e = sb.pop_front();
        total++;
        if ({iw_valid, iw, ma, pc} !== {1'b1, e})
            $display("FAIL rmid_issue: got v=%b %h %h %h want 1 %h", iw_valid, iw, ma, pc, e);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_one_byte();
        test_two_byte();
        test_backpressure();
        test_jump();
        test_wrap();
        test_count_wrap();
        test_reset_mid();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ajc_instr_fetch.md
# ajc_instr_fetch

Instruction fetch stage for the 8-bit RISC core. It reads instruction bytes from program memory and assembles one- or two-byte instructions. It presents the instruction word (IW) and optional memory-address operand (MA) to the control unit and the IW-to-ASCII debug decoder, using a valid/ready handshake. It also owns the program counter and accepts jump redirects from the control unit.

## Interface
- AW, 8, program-memory address width (PC width)
- CW, 16, width of retired-instruction counter

- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- PM_Addr  out  AW  program-memory read address (equals PC)
- PM_Rd  out  1  program-memory read strobe
- PM_Data  in  8  program-memory read data, valid the cycle after PM_Rd
- IW  out  8  current instruction word
- MA  out  8  second byte of LD/ST/JUMP (address operand); 0 for one-byte instructions
- IW_Valid  out  1  IW/MA hold a complete instruction
- CU_Ready  in  1  control unit consumes IW/MA when high with IW_Valid
- Redirect  in  1  taken jump; load PC from Redirect_Addr
- Redirect_Addr  in  AW  jump target
- PC  out  AW  next fetch address
- InstrCount  out  CW  number of handshakes completed since reset

## Operation
- The FSM has 5 states: FETCH, WAIT_IW, FETCH_MA, WAIT_MA, ISSUE.
- FETCH: PM_Rd=1, PM_Addr=PC. The next state is WAIT_IW.
- WAIT_IW: IW<=PM_Data; MA<=0; PC<=PC+1.
  - If PM_Data[7:4] is 4'b1011 (LD), 4'b1100 (ST) or 4'b1101 (JUMP), the next state is FETCH_MA.
  - Otherwise the next state is ISSUE.
- FETCH_MA: PM_Rd=1, PM_Addr=PC. The next state is WAIT_MA.
- WAIT_MA: MA<=PM_Data; PC<=PC+1. The next state is ISSUE.
- ISSUE: IW_Valid=1; IW and MA are held stable.
  - When CU_Ready=1, InstrCount<=InstrCount+1 and the next state is FETCH.
  - If Redirect=1 in the same cycle, PC<=Redirect_Addr.
  - When CU_Ready=0, the FSM stays in ISSUE and ignores Redirect.
- Redirect is sampled only in ISSUE with CU_Ready=1. It is ignored in all other states.
- PM_Rd and IW_Valid decode from the state and are forced to 0 while Reset=1.
- Width rules:
  - PC increments modulo 2^AW, so FF+1 gives 00.
  - A two-byte opcode at FF takes its operand from 00.
  - InstrCount wraps modulo 2^CW.
- Reset sets: state=FETCH, PC=0, IW=0, MA=0, InstrCount=0, IW_Valid=0, PM_Rd=0.
- Reset mid-operation aborts any partial instruction. No handshake completes in the reset cycle, and InstrCount does not increment.

## Timing
- Latency from Reset deasserted (cycle 0):
  - PM_Rd=1 in cycle 0.
  - IW captured at the end of cycle 1.
  - For a one-byte instruction, IW_Valid=1 in cycle 2.
- One-byte instruction: 3 cycles from FETCH to the first ISSUE cycle. Throughput is one instruction per 3 cycles with CU_Ready tied high.
- Two-byte instruction: 5 cycles, throughput 1 per 5.
- IW, MA and PC are registered. PM_Addr is a direct copy of PC.
- Redirect takes effect in the next FETCH, which is the cycle after the handshake. No wrong-path byte is fetched, because fetch stalls in ISSUE.
- IW_Valid drops in the cycle after the handshake.
- IW keeps its old value until the next WAIT_IW overwrites it.

## Test plan
- Reset, then memory[00]=8'h06 (ADD R1,R2) with CU_Ready=1:
  - cycle 0: PM_Rd=1, PM_Addr=00
  - cycle 2: IW_Valid=1, IW=06, MA=00, PC=01
  - cycle 3: InstrCount=1, PM_Addr=01
- memory[00..01]=B4,20 (LD R1,M[20]):
  - cycle 4: IW_Valid=1, IW=B4, MA=20, PC=02
  - PM_Rd is seen at addresses 00 and 01 only.
- Backpressure: CU_Ready=0 for 5 cycles during ISSUE.
  - IW_Valid, IW, MA and PC stay constant throughout.
  - No PM_Rd is issued.
  - Redirect pulses during the stall are ignored.
  - After CU_Ready=1, InstrCount increments exactly once.
- JUMP: memory[10..11]=D1,40. At handshake, Redirect=1 and Redirect_Addr=40.
  - The next cycle shows PM_Addr=40 and PM_Rd=1.
  - Address 12 is never read.
- Wrap: PC=FF with memory[FF]=C8 (ST) and memory[00]=33.
  - Result: IW=C8, MA=33, PC=01.
  - Separately, with CW=4, 17 handshakes give InstrCount=1.
- Reset asserted in WAIT_MA. In that cycle IW_Valid=0 and PM_Rd=0.
  - Next cycle: PC=0, IW=0, MA=0, InstrCount=0.
  - Fetch restarts at 00.
